// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: widths, gain constant, FSM encoding and the
// micro-rotation arithmetic used by both vectoring and rotation cells.
package cordic_pkg;

    localparam int         INOUT_WIDTH  = 16;
    localparam int         ITER_NUM_DEF = 9;
    localparam int         XW           = INOUT_WIDTH + 1;
    localparam logic [6:0] K_CONST_DEF  = 7'b0100111;
    localparam int         K_FRAC       = 6;

    typedef logic signed [XW-1:0] xw_t;

    typedef struct packed {
        xw_t x;
        xw_t y;
    } xy_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ITER  = 2'd1,
        S_SCALE = 2'd2
    } state_e;

    // y == 0 counts as non-negative, so only the sign bits matter
    function automatic logic dir_bit(input xw_t x, input xw_t y);
        return x[XW-1] ^ y[XW-1];
    endfunction

    function automatic xy_t micro_rot(input xw_t x, input xw_t y,
                                      input logic d, input logic [3:0] shift);
        logic signed [XW:0] xe;
        logic signed [XW:0] ye;
        logic signed [XW:0] xs;
        logic signed [XW:0] ys;
        logic signed [XW:0] sx;
        logic signed [XW:0] sy;
        xy_t                res;
        xe = {x[XW-1], x};
        ye = {y[XW-1], y};
        xs = xe >>> shift;
        ys = ye >>> shift;
        if (d) begin
            sx = xe - ys;
            sy = ye + xs;
        end else begin
            sx = xe + ys;
            sy = ye - xs;
        end
        // keep the true sign on top of the low INOUT_WIDTH bits
        res.x         = xw_t'(sx);
        res.x[XW-1]   = sx[XW];
        res.y         = xw_t'(sy);
        res.y[XW-1]   = sy[XW];
        return res;
    endfunction

endpackage

// File: rtl/cordic_micro_rot.sv
// One combinational CORDIC micro-rotation stage (x, y, d, shift -> x', y').
module cordic_micro_rot
    import cordic_pkg::*;
(
    input  xw_t        i_x,
    input  xw_t        i_y,
    input  logic       i_d,
    input  logic [3:0] i_shift,
    output xw_t        o_x,
    output xw_t        o_y
);

    xy_t res_s;

    // apply the shared package arithmetic
    always_comb begin
        res_s = micro_rot(i_x, i_y, i_d, i_shift);
    end

    assign o_x = res_s.x;
    assign o_y = res_s.y;

endmodule

// File: rtl/cordic_vectoring.sv
// Vectoring-mode CORDIC boundary cell: streams one direction bit per
// iteration, then emits the gain-compensated magnitude of (x, y).
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int         ITER_NUM = ITER_NUM_DEF,
    parameter logic [6:0] K_CONST  = K_CONST_DEF
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_data_valid,
    input  logic signed [INOUT_WIDTH-1:0] i_data_x,
    input  logic signed [INOUT_WIDTH-1:0] i_data_y,
    output logic                          o_ready,
    output logic                          o_d_valid,
    output logic                          o_d,
    output logic                          o_data_valid,
    output logic signed [INOUT_WIDTH-1:0] o_r
);

    localparam logic [3:0] LAST_ITER = 4'(ITER_NUM - 1);
    localparam int         PW        = INOUT_WIDTH + K_FRAC;

    state_e                        state_q;
    state_e                        state_d;
    logic [3:0]                    iter_q;
    logic [3:0]                    iter_d;
    xw_t                           x_q;
    xw_t                           x_d;
    xw_t                           y_q;
    xw_t                           y_d;
    logic                          d_q;
    logic                          d_d;
    logic                          d_valid_q;
    logic                          d_valid_d;
    logic signed [INOUT_WIDTH-1:0] r_q;
    logic signed [INOUT_WIDTH-1:0] r_d;
    logic                          r_valid_q;
    logic                          r_valid_d;

    xw_t                           op_x_s;
    xw_t                           op_y_s;
    xw_t                           rot_x_s;
    xw_t                           rot_y_s;
    logic                          dir_s;
    logic signed [PW-1:0]          prod_s;

    // iteration 0 works straight off the inputs, later ones off the registers
    always_comb begin
        if (state_q == S_IDLE) begin
            op_x_s = {i_data_x[INOUT_WIDTH-1], i_data_x};
            op_y_s = {i_data_y[INOUT_WIDTH-1], i_data_y};
        end else begin
            op_x_s = x_q;
            op_y_s = y_q;
        end
        dir_s = dir_bit(op_x_s, op_y_s);
    end

    cordic_micro_rot u_micro_rot (
        .i_x     (op_x_s),
        .i_y     (op_y_s),
        .i_d     (dir_s),
        .i_shift (iter_q),
        .o_x     (rot_x_s),
        .o_y     (rot_y_s)
    );

    // gain compensation; only the low PW product bits survive the >>> 6 and truncation
    always_comb begin
        prod_s = $signed({{(PW-XW){x_q[XW-1]}}, x_q}) * $signed({{(PW-7){1'b0}}, K_CONST});
    end

    // next-state and datapath update
    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        x_d       = x_q;
        y_d       = y_q;
        d_d       = d_q;
        d_valid_d = 1'b0;
        r_d       = r_q;
        r_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_data_valid) begin
                    x_d       = rot_x_s;
                    y_d       = rot_y_s;
                    d_d       = dir_s;
                    d_valid_d = 1'b1;
                    iter_d    = 4'd1;
                    if (ITER_NUM == 1) begin
                        state_d = S_SCALE;
                    end else begin
                        state_d = S_ITER;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ITER: begin
                x_d       = rot_x_s;
                y_d       = rot_y_s;
                d_d       = dir_s;
                d_valid_d = 1'b1;
                iter_d    = iter_q + 4'd1;
                if (iter_q == LAST_ITER) begin
                    state_d = S_SCALE;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_SCALE: begin
                r_d       = INOUT_WIDTH'(prod_s >>> K_FRAC);
                r_valid_d = 1'b1;
                iter_d    = 4'd0;
                state_d   = S_IDLE;
            end
            default: begin
                iter_d  = 4'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            iter_q    <= 4'd0;
            x_q       <= '0;
            y_q       <= '0;
            d_q       <= 1'b0;
            d_valid_q <= 1'b0;
            r_q       <= '0;
            r_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            x_q       <= x_d;
            y_q       <= y_d;
            d_q       <= d_d;
            d_valid_q <= d_valid_d;
            r_q       <= r_d;
            r_valid_q <= r_valid_d;
        end
    end

    assign o_ready      = (state_q == S_IDLE);
    assign o_d          = d_q;
    assign o_d_valid    = d_valid_q;
    assign o_r          = r_q;
    assign o_data_valid = r_valid_q;

endmodule
